// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle processor: opcodes, time steps, ALU codes, IR fields.
package proc_pkg;

  typedef enum logic [1:0] {
    T0 = 2'b00,
    T1 = 2'b01,
    T2 = 2'b10,
    T3 = 2'b11
  } step_t;

  localparam logic [3:0] OP_MV   = 4'b0000;
  localparam logic [3:0] OP_MVI  = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLL  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_MVNZ = 4'b1000;

  localparam logic [2:0] ALU_NONE = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLL  = 3'b110;
  localparam logic [2:0] ALU_SRL  = 3'b111;

  localparam int IR_OP_MSB = 9;
  localparam int IR_OP_LSB = 6;
  localparam int IR_X_MSB  = 5;
  localparam int IR_X_LSB  = 3;
  localparam int IR_Y_MSB  = 2;
  localparam int IR_Y_LSB  = 0;

endpackage

// File: rtl/dec3to8.sv
// 3-bit register index to one-hot select, gated by an enable.
module dec3to8 #(
  parameter int NREG = 8
) (
  input  logic            i_en,
  input  logic [2:0]      i_sel,
  output logic [NREG-1:0] o_onehot
);

  assign o_onehot = i_en ? (NREG'(1) << i_sel) : '0;

endmodule

// File: rtl/unidade_controle_ir.sv
// Control unit sequencing T0..T3 from the instruction register.
// Optional macro ILLEGAL_OP_TRAP_EN: illegal opcodes set a sticky Err and park the FSM until reset.
module unidade_controle_ir
  import proc_pkg::*;
#(
  parameter int NREG = 8,
  parameter int IRW  = 10
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Run,
  input  logic [IRW-1:0]  IR,
  input  logic            Gz,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            Ain,
  output logic            Gin,
  output logic            Gout,
  output logic            DINout,
  output logic [2:0]      AluOp,
  output logic            Done,
  output logic [1:0]      Step,
  output logic            Err
);

  step_t      r_step;
  step_t      w_next;
  logic [3:0] w_op;
  logic [2:0] w_x;
  logic [2:0] w_y;
  logic [2:0] w_rout_sel;
  logic       w_rin_en;
  logic       w_rout_en;
  logic       w_rout_sel_x;
  logic       w_parked;
  logic       w_set_err;

  assign w_op       = IR[IR_OP_MSB:IR_OP_LSB];
  assign w_x        = IR[IR_X_MSB:IR_X_LSB];
  assign w_y        = IR[IR_Y_MSB:IR_Y_LSB];
  assign w_rout_sel = w_rout_sel_x ? w_x : w_y;

  dec3to8 #(.NREG(NREG)) u_dec_rin (
    .i_en     (w_rin_en),
    .i_sel    (w_x),
    .o_onehot (Rin)
  );

  dec3to8 #(.NREG(NREG)) u_dec_rout (
    .i_en     (w_rout_en),
    .i_sel    (w_rout_sel),
    .o_onehot (Rout)
  );

  always_ff @(posedge Clock) begin
    if (!Resetn) r_step <= T0;
    else         r_step <= w_next;
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic r_err;

  always_ff @(posedge Clock) begin
    if (!Resetn)        r_err <= 1'b0;
    else if (w_set_err) r_err <= 1'b1;
  end

  assign w_parked = r_err;
  assign Err      = r_err;
`else
  assign w_parked = 1'b0;
  assign Err      = 1'b0;
`endif

  always_comb begin
    w_next       = r_step;
    w_set_err    = 1'b0;
    w_rin_en     = 1'b0;
    w_rout_en    = 1'b0;
    w_rout_sel_x = 1'b0;
    IRin         = 1'b0;
    Ain          = 1'b0;
    Gin          = 1'b0;
    Gout         = 1'b0;
    DINout       = 1'b0;
    AluOp        = ALU_NONE;
    Done         = 1'b0;
    case (r_step)
      T0: begin
        // A trapped illegal opcode blocks new fetches until reset.
        if (!w_parked) begin
          IRin = Run;
          if (Run) w_next = T1;
        end
      end
      T1: begin
        w_next = T0;
        case (w_op)
          OP_MV: begin
            w_rout_en = 1'b1;
            w_rin_en  = 1'b1;
            Done      = 1'b1;
          end
          OP_MVI: begin
            DINout   = 1'b1;
            w_rin_en = 1'b1;
            Done     = 1'b1;
          end
          OP_MVNZ: begin
            w_rout_en = !Gz;
            w_rin_en  = !Gz;
            Done      = 1'b1;
          end
          OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_SLL, OP_SRL: begin
            w_rout_en    = 1'b1;
            w_rout_sel_x = 1'b1;
            Ain          = 1'b1;
            w_next       = T2;
          end
          default: begin
`ifdef ILLEGAL_OP_TRAP_EN
            w_set_err = 1'b1;
`else
            Done = 1'b1;
`endif
          end
        endcase
      end
      T2: begin
        w_rout_en = 1'b1;
        Gin       = 1'b1;
        AluOp     = w_op[2:0];
        w_next    = T3;
      end
      T3: begin
        Gout     = 1'b1;
        w_rin_en = 1'b1;
        Done     = 1'b1;
        w_next   = T0;
      end
      default: w_next = T0;
    endcase
  end

  assign Step = r_step;

endmodule
